// File: rtl/dmem_arb_pkg.sv
// +----------------------------------------------------------------------------+
// | dmem_arb_pkg : shared constants and state encoding for dmem_arbiter        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package dmem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned LINE_W_DEF = 256;
  localparam int unsigned LINE_OFS_W = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY0 = 2'd1;
  localparam logic [1:0] ST_BUSY1 = 2'd2;

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// +----------------------------------------------------------------------------+
// | rr_pick2 : two-requester combinational picker, one-hot grant               |
// | Macro ARB_FIXED_PRIO_EN selects fixed priority (port 1 wins ties).         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

`ifdef ARB_FIXED_PRIO_EN
  logic w_unused_last_grant;
  assign w_unused_last_grant = last_grant;

  always_comb begin
    gnt = 2'b00;
    if (req[1]) begin
      gnt = 2'b10;
    end else if (req[0]) begin
      gnt = 2'b01;
    end
  end
`else
  // On a tie the port that did not win last time is served.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end
`endif

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// +----------------------------------------------------------------------------+
// | dmem_arbiter : shares one line-wide data memory between icache and dcache  |
// | Macro ARB_FIXED_PRIO_EN: port 1 always wins ties (default round-robin).    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [LINE_W-1:0] m0_data_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  output logic [LINE_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [LINE_W-1:0] m1_data_i,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  output logic [LINE_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o
);

  localparam logic [ADDR_W-1:0] c_line_mask = ~ADDR_W'((1 << LINE_OFS_W) - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_last_grant;
  logic [1:0]        w_gnt;
  logic              w_grant_fire;
  logic              w_busy;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [LINE_W-1:0] w_sel_data;
  logic              w_sel_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LINE_W-1:0] r_mem_data;
  logic              r_mem_enable;
  logic              r_mem_write;

  rr_pick2 u_pick (
    .req        ({m1_enable_i, m0_enable_i}),
    .last_grant (r_last_grant),
    .gnt        (w_gnt)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt[0]) begin
          w_state_nxt = ST_BUSY0;
        end else if (w_gnt[1]) begin
          w_state_nxt = ST_BUSY1;
        end
      end
      ST_BUSY0, ST_BUSY1: begin
        if (mem_ack_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Acks are steered straight from memory so the cache sees them the same cycle.
  always_comb begin
    m0_ack_o     = 1'b0;
    m1_ack_o     = 1'b0;
    w_grant_fire = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      ST_IDLE: w_grant_fire = |w_gnt;
      ST_BUSY0: begin
        m0_ack_o = mem_ack_i;
        w_busy   = 1'b1;
      end
      ST_BUSY1: begin
        m1_ack_o = mem_ack_i;
        w_busy   = 1'b1;
      end
      default: begin
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
      end
    endcase
  end

  assign w_sel_addr  = w_gnt[1] ? m1_addr_i  : m0_addr_i;
  assign w_sel_data  = w_gnt[1] ? m1_data_i  : m0_data_i;
  assign w_sel_write = w_gnt[1] ? m1_write_i : m0_write_i;

  // Request is captured at grant and held frozen until the memory acks.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mem_enable <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_last_grant <= 1'b1;
    end else if (w_grant_fire) begin
      r_mem_enable <= 1'b1;
      r_mem_write  <= w_sel_write;
      r_mem_addr   <= w_sel_addr & c_line_mask;
      r_mem_data   <= w_sel_data;
      r_last_grant <= w_gnt[1];
    end else if (w_busy && mem_ack_i) begin
      r_mem_enable <= 1'b0;
      r_mem_write  <= 1'b0;
    end
  end

  assign mem_enable_o = r_mem_enable;
  assign mem_write_o  = r_mem_write;
  assign mem_addr_o   = r_mem_addr;
  assign mem_data_o   = r_mem_data;
  assign m0_data_o    = mem_data_i;
  assign m1_data_o    = mem_data_i;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_dmem_arbiter : randomized scoreboard bench for dmem_arbiter             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam logic [31:0] c_addr_mask = 32'hFFFF_FFE0;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [ADDR_W-1:0] m0_addr_i, m1_addr_i;
  logic [LINE_W-1:0] m0_data_i, m1_data_i;
  logic              m0_enable_i, m1_enable_i, m0_write_i, m1_write_i;
  logic [LINE_W-1:0] m0_data_o, m1_data_o;
  logic              m0_ack_o, m1_ack_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;
  logic [LINE_W-1:0] mem_data_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_enable_o, mem_write_o;

  always #5 clk_i = ~clk_i;

  dmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_enable_i(m0_enable_i),
    .m0_write_i(m0_write_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_enable_i(m1_enable_i),
    .m1_write_i(m1_write_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i), .mem_data_o(mem_data_o),
    .mem_addr_o(mem_addr_o), .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o)
  );

  typedef struct {
    int               port;
    logic [31:0]      addr;
    logic [255:0]     data;
    logic             wr;
  } txn_t;

  txn_t         exp_q[$];
  int           grant_log[$];
  int           total = 0;
  int           bad = 0;
  int           model_last = 1;
  bit           ack_seen0, ack_seen1;
  int           mem_delay = 2;
  bit           mem_rand_delay = 1'b0;
  bit           mem_fixed_fill = 1'b0;
  bit           inject_spurious = 1'b0;
  logic [255:0] line_a5 = {32{8'hA5}};
  logic [255:0] last_ack_data0;

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: serve order follows from who requests and who was served last.
  function automatic void model_round(input bit r0, input bit r1, input txn_t t0, input txn_t t1);
    int first;
    if (r0 && r1) begin
`ifdef ARB_FIXED_PRIO_EN
      first = 1;
`else
      first = (model_last == 1) ? 0 : 1;
`endif
      exp_q.push_back(first == 0 ? t0 : t1);
      exp_q.push_back(first == 0 ? t1 : t0);
      model_last = 1 - first;
    end else if (r0) begin
      exp_q.push_back(t0);
      model_last = 0;
    end else if (r1) begin
      exp_q.push_back(t1);
      model_last = 1;
    end
  endfunction

  // Memory model: acks a request after a programmable delay.
  initial begin
    int cnt;
    bit sent;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    cnt  = 0;
    sent = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0;
      if (!mem_enable_o || rst_i) begin
        sent = 1'b0;
        cnt  = mem_rand_delay ? $urandom_range(0, 5) : mem_delay;
        if (inject_spurious && !rst_i) begin
          mem_ack_i       = 1'b1;
          mem_data_i      = rand_line();
          inject_spurious = 1'b0;
        end
      end else if (!sent) begin
        if (cnt == 0) begin
          mem_ack_i  = 1'b1;
          mem_data_i = mem_fixed_fill ? line_a5 : rand_line();
          sent       = 1'b1;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Monitor / scoreboard
  bit   mon_prev_en = 1'b0, mon_active = 1'b0, mon_acked = 1'b0, mon_hold_bad = 1'b0;
  txn_t mon_cur;
  initial begin
    forever begin
      @(negedge clk_i);
      ack_seen0 = ack_seen0 | m0_ack_o;
      ack_seen1 = ack_seen1 | m1_ack_o;
      if (rst_i) begin
        mon_prev_en = 1'b0;
        mon_active  = 1'b0;
        continue;
      end
      if (mem_enable_o && !mon_prev_en) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_request actual addr=%h required none", mem_addr_o);
          mon_active = 1'b0;
        end else begin
          mon_cur = exp_q.pop_front();
          mon_active = 1'b1;
          mon_acked = 1'b0;
          mon_hold_bad = 1'b0;
          check("req_addr", mem_addr_o, mon_cur.addr);
          check("req_write", mem_write_o, mon_cur.wr);
          if (mon_cur.wr) check("req_wdata", mem_data_o, mon_cur.data);
        end
      end
      if (mem_enable_o && mon_active) begin
        if (mem_addr_o !== mon_cur.addr || mem_write_o !== mon_cur.wr ||
            (mon_cur.wr && mem_data_o !== mon_cur.data)) mon_hold_bad = 1'b1;
      end
      if (mem_ack_i) begin
        if (mon_active && mem_enable_o) begin
          check("ack0", m0_ack_o, mon_cur.port == 0);
          check("ack1", m1_ack_o, mon_cur.port == 1);
          check("rdata0", m0_data_o, mem_data_i);
          check("rdata1", m1_data_o, mem_data_i);
          check("req_held", mon_hold_bad, 1'b0);
          mon_acked = 1'b1;
          if (m0_ack_o) last_ack_data0 = m0_data_o;
          if (m0_ack_o) grant_log.push_back(0);
          if (m1_ack_o) grant_log.push_back(1);
        end else begin
          check("spurious_ack", {m1_ack_o, m0_ack_o}, 2'b00);
        end
      end
      if (!mem_enable_o && mon_prev_en && mon_active) begin
        check("acked_before_release", mon_acked, 1'b1);
        mon_active = 1'b0;
      end
      mon_prev_en = mem_enable_o;
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    m0_enable_i = 1'b0; m1_enable_i = 1'b0;
    rst_i = 1'b1;
    repeat (2) tick();
    rst_i = 1'b0;
    model_last = 1;
  endtask

  task automatic run_round(input bit r0, input bit r1, input logic [31:0] a0, input logic [31:0] a1,
                           input bit w0, input bit w1, input bit drop);
    txn_t t0, t1;
    int   cyc;
    bit   d0, d1, single;
    t0.port = 0; t0.addr = a0; t0.data = rand_line(); t0.wr = w0;
    t1.port = 1; t1.addr = a1; t1.data = rand_line(); t1.wr = w1;
    model_round(r0, r1, t0, t1);
    ack_seen0 = 1'b0; ack_seen1 = 1'b0;
    m0_addr_i = a0; m0_data_i = t0.data; m0_write_i = w0; m0_enable_i = r0;
    m1_addr_i = a1; m1_data_i = t1.data; m1_write_i = w1; m1_enable_i = r1;
    d0 = !r0; d1 = !r1; single = r0 ^ r1; cyc = 0;
    while (!(d0 && d1) && cyc < 400) begin
      tick();
      cyc++;
      if (ack_seen0) begin m0_enable_i = 1'b0; ack_seen0 = 1'b0; d0 = 1'b1; end
      if (ack_seen1) begin m1_enable_i = 1'b0; ack_seen1 = 1'b0; d1 = 1'b1; end
      // The lone request is latched after the first edge; disturb its inputs afterwards.
      if (single && r0 && !d0) begin
        m0_data_i = rand_line(); m0_addr_i = $urandom & c_addr_mask; m0_write_i = 1'($urandom);
        if (drop) m0_enable_i = 1'b0;
      end
      if (single && r1 && !d1) begin
        m1_data_i = rand_line(); m1_addr_i = $urandom & c_addr_mask; m1_write_i = 1'($urandom);
        if (drop) m1_enable_i = 1'b0;
      end
    end
    if (!(d0 && d1)) begin
      total++; bad++;
      $display("FAIL round_timeout actual done=%b%b required 11", d1, d0);
    end
  endtask

  initial begin
    int exp_tie[$];
    int n;
    m0_addr_i = '0; m1_addr_i = '0; m0_data_i = '0; m1_data_i = '0;
    m0_write_i = 1'b0; m1_write_i = 1'b0; m0_enable_i = 1'b0; m1_enable_i = 1'b0;
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("rst_enable", mem_enable_o, 1'b0);
    check("rst_write", mem_write_o, 1'b0);
    check("rst_addr", mem_addr_o, '0);
    check("rst_data", mem_data_o, '0);
    check("rst_acks", {m1_ack_o, m0_ack_o}, 2'b00);
    tick();
    rst_i = 1'b0;
    tick();

    // single read at 0x400, 0xA5 line after ~10 cycles
    mem_fixed_fill = 1'b1; mem_delay = 9;
    run_round(1'b1, 1'b0, 32'h400, 32'h0, 1'b0, 1'b0, 1'b0);
    check("single_read_line", last_ack_data0, line_a5);
    mem_fixed_fill = 1'b0; mem_delay = 2;
    tick();

    // ties from reset
    do_reset();
    grant_log.delete();
`ifdef ARB_FIXED_PRIO_EN
    exp_tie = '{1, 0, 1, 0, 1, 0};
`else
    exp_tie = '{0, 1, 0, 1, 0, 1};
`endif
    for (int i = 0; i < 3; i++)
      run_round(1'b1, 1'b1, $urandom & c_addr_mask, $urandom & c_addr_mask, 1'b0, 1'b1, 1'b0);
    check("tie_count", grant_log.size(), 6);
    n = (grant_log.size() < 6) ? grant_log.size() : 6;
    for (int i = 0; i < n; i++) check("tie_order", grant_log[i], exp_tie[i]);

    // write latch on port 1 with disturbed inputs
    mem_delay = 5;
    run_round(1'b0, 1'b1, 32'h0, 32'h7E0, 1'b0, 1'b1, 1'b0);

    // early drop on port 0
    run_round(1'b1, 1'b0, $urandom & c_addr_mask, 32'h0, 1'b0, 1'b0, 1'b1);

    // spurious ack while idle
    repeat (2) tick();
    ack_seen0 = 1'b0; ack_seen1 = 1'b0;
    inject_spurious = 1'b1;
    repeat (4) tick();
    check("spurious_no_ack", {ack_seen1, ack_seen0}, 2'b00);

    // reset in the middle of a BUSY0 transaction
    mem_delay = 20;
    begin
      txn_t ta, tb;
      ta.port = 0; ta.addr = 32'h1240; ta.data = '0; ta.wr = 1'b0;
      tb = ta;
      model_round(1'b1, 1'b0, ta, tb);
    end
    m0_addr_i = 32'h1240; m0_write_i = 1'b0; m0_enable_i = 1'b1;
    ack_seen0 = 1'b0;
    repeat (3) tick();
    check("busy_before_abort", mem_enable_o, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    check("abort_enable_async", mem_enable_o, 1'b0);
    check("abort_acks", {m1_ack_o, m0_ack_o}, 2'b00);
    m0_enable_i = 1'b0;
    repeat (2) tick();
    rst_i = 1'b0;
    model_last = 1;
    repeat (4) tick();
    check("abort_no_ack", ack_seen0, 1'b0);

    // randomized traffic
    mem_rand_delay = 1'b1;
    for (int i = 0; i < 150; i++) begin
      int sel;
      bit r0, r1;
      sel = $urandom_range(1, 3);
      r0 = sel[0]; r1 = sel[1];
      run_round(r0, r1, $urandom & c_addr_mask, $urandom & c_addr_mask,
                1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (5) tick();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1);
  end

endmodule

`default_nettype wire
